playfield_mem_arbiter: RTL and testbench
========================================

Name: playfield_mem_arbiter

Overview:
- Shares one single-port playfield RAM between three users: the HDMI scanout path (cell colour fetch for the TMDS encoders), the Tetris game logic (read/write one cell per request) and a bulk board-clear sequencer.
- Sits between the pixel-generation logic feeding R/G/B_data and the game state machine.
- Scanout always wins, so video timing is never disturbed.

Parameters:
- COLS, 10, playfield width in cells
- ROWS, 20, playfield height in cells
- CW, 3, colour code width per cell
- AW, 8, cell address width (must satisfy 2^AW >= COLS*ROWS)

Ports:
- pixclk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- disp_req  in  1  scanout fetch request, one per cycle, no handshake
- disp_addr  in  AW  cell index for the scanout fetch
- disp_data  out  CW  fetched colour, registered
- disp_vld  out  1  disp_data valid pulse
- game_req  in  1  game access request, held until granted
- game_we  in  1  1 = write, 0 = read
- game_addr  in  AW  game cell index
- game_wdata  in  CW  game write data
- game_gnt  out  1  one-cycle accept pulse, combinational
- game_rdata  out  CW  game read data, registered
- game_rvld  out  1  game_rdata valid pulse
- clear_start  in  1  pulse: start a full-board clear to colour 0
- clear_busy  out  1  clear in progress
- addr_err  out  1  sticky: game address >= COLS*ROWS was presented; cleared only by reset
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  CW  RAM write data
- mem_rdata  in  CW  RAM read data, valid one cycle after a read is issued

Behaviour:
- Reset (asynchronous, active-high):
  - All registered outputs go to 0: disp_data, disp_vld, game_rdata, game_rvld, clear_busy, addr_err.
  - FSM returns to IDLE, clear counter goes to 0 and the read-owner pipeline is flushed.
  - A reset mid-clear aborts the clear. No resume.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clear_start.
  - CLEAR -> IDLE in the cycle after the write to address COLS*ROWS-1 is issued.
  - clear_busy = (state == CLEAR).
  - clear_start while in CLEAR is ignored; the counter does not restart.
- Per-cycle priority is scanout > clear > game.
  - disp_req=1: RAM read at disp_addr. No clear write or game access is issued that cycle.
  - Else, in CLEAR: write 0 at clr_cnt, then clr_cnt increments. The counter advances only in cycles the clear is actually issued.
  - Else, game_req=1 in IDLE:
    - game_gnt=1.
    - In-range address: RAM access at game_addr, with game_we and game_wdata.
    - Out-of-range address: no RAM access and addr_err is set.
  - game_gnt is 0 in every cycle where disp_req=1 or clear_busy=1.
  - The game side must hold game_req, game_addr, game_we and game_wdata stable until game_gnt. Starvation by scanout is permitted; the game logic updates during blanking.
- Read latency:
  - A read issued in cycle N has RAM data in cycle N+1 and produces the registered result plus valid pulse in cycle N+2.
  - A 2-bit owner tag per pipeline stage routes the result to disp_* or game_*.
  - Back-to-back scanout reads give disp_vld high continuously, with latency 2.
- Game reads:
  - game_rvld pulses exactly 2 cycles after game_gnt for every granted read.
  - An out-of-range read returns game_rdata = 0.
  - Granted writes produce no rvld.
- Simultaneous clear_start and game_req in IDLE: the clear wins from that cycle. The game request is not granted until the clear completes.
- disp_data and game_rdata hold their last value when their valid signal is low.
- mem_* are driven combinationally from the arbitration decision. mem_en=0 when idle or on an out-of-range game access.

Test Plan:
- Reset, then game write addr=5 data=3 with disp_req=0 -> game_gnt the same cycle, mem_we=1 with mem_addr=5; a later game read addr=5 -> game_rvld 2 cycles after gnt with game_rdata=3.
- disp_req held high for 8 cycles while game_req is pending -> game_gnt=0 throughout; disp_vld high cycles 2..9; game granted the first cycle disp_req=0.
- clear_start with disp_req toggling every other cycle -> exactly 200 zero writes, addresses 0..199 in order, clear_busy low after the last one; a readback of address 5 returns 0.
- Game read addr=200 -> gnt, mem_en=0, addr_err=1 and stays 1, game_rvld after 2 cycles with data 0.
- Reset asserted at clear write #50 -> all outputs 0 immediately; after release a new clear_start restarts at address 0.
- clear_start and game_req in the same IDLE cycle -> clear writes address 0; the game is granted only after clear_busy falls.

Source files
------------

// File: rtl/playfield_mem_arbiter_if.sv
// Bus bundle between the playfield RAM arbiter and its three users plus the RAM.
// The slave modport is the arbiter's view; master is the surrounding logic and RAM.
interface playfield_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int CW = 3
);
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [CW-1:0] disp_data;
  logic          disp_vld;
  logic          game_req;
  logic          game_we;
  logic [AW-1:0] game_addr;
  logic [CW-1:0] game_wdata;
  logic          game_gnt;
  logic [CW-1:0] game_rdata;
  logic          game_rvld;
  logic          clear_start;
  logic          clear_busy;
  logic          addr_err;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clear_start, mem_rdata,
    output disp_data, disp_vld, game_gnt, game_rdata, game_rvld,
           clear_busy, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, game_req, game_we, game_addr, game_wdata,
           clear_start, mem_rdata,
    input  disp_data, disp_vld, game_gnt, game_rdata, game_rvld,
           clear_busy, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/playfield_mem_arbiter.sv
// Single-port playfield RAM arbiter: scanout > board clear > game access,
// with a two-stage owner-tagged read pipeline returning data to scanout or game.
module playfield_mem_arbiter #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int CW   = 3,
  parameter int AW   = 8
) (
  input logic                     pixclk,
  input logic                     reset,
  playfield_mem_arbiter_if.slave  bus
);

  localparam int            NCELLS    = COLS * ROWS;
  localparam logic [AW-1:0] LAST_CELL = AW'(NCELLS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE     = 2'd0,
    TAG_DISP     = 2'd1,
    TAG_GAME     = 2'd2,
    TAG_GAME_OOR = 2'd3
  } tag_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_clr_cnt;
  tag_t          r_tag;
  tag_t          w_tag;
  logic [CW-1:0] r_disp_data;
  logic          r_disp_vld;
  logic [CW-1:0] r_game_rdata;
  logic          r_game_rvld;
  logic          r_addr_err;

  logic          w_mem_en;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [CW-1:0] w_mem_wdata;
  logic          w_game_gnt;
  logic          w_clr_issue;
  logic          w_addr_err_set;
  logic          w_game_in_range;

  assign w_game_in_range = (bus.game_addr <= LAST_CELL);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A clear_start in IDLE blocks the game grant that same cycle; the first
  // clear write goes out once the FSM is in CLEAR.
  always_comb begin
    w_next_state   = r_state;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_game_gnt     = 1'b0;
    w_clr_issue    = 1'b0;
    w_addr_err_set = 1'b0;
    w_tag          = TAG_NONE;

    if (bus.disp_req) begin
      w_mem_en   = 1'b1;
      w_mem_addr = bus.disp_addr;
      w_tag      = TAG_DISP;
    end else if (r_state == CLEAR) begin
      w_mem_en    = 1'b1;
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_cnt;
      w_clr_issue = 1'b1;
    end else if (bus.game_req && !bus.clear_start) begin
      w_game_gnt = 1'b1;
      if (w_game_in_range) begin
        w_mem_en    = 1'b1;
        w_mem_we    = bus.game_we;
        w_mem_addr  = bus.game_addr;
        w_mem_wdata = bus.game_wdata;
        w_tag       = bus.game_we ? TAG_NONE : TAG_GAME;
      end else begin
        w_addr_err_set = 1'b1;
        w_tag          = bus.game_we ? TAG_NONE : TAG_GAME_OOR;
      end
    end

    case (r_state)
      IDLE:    if (bus.clear_start) w_next_state = CLEAR;
      CLEAR:   if (w_clr_issue && (r_clr_cnt == LAST_CELL)) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_clr_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_clr_cnt <= '0;
    end else if (w_clr_issue) begin
      r_clr_cnt <= (r_clr_cnt == LAST_CELL) ? '0 : r_clr_cnt + AW'(1);
    end
  end

  // Stage 1 tag lines up with mem_rdata; stage 2 registers the routed result.
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_tag        <= TAG_NONE;
      r_disp_data  <= '0;
      r_disp_vld   <= 1'b0;
      r_game_rdata <= '0;
      r_game_rvld  <= 1'b0;
    end else begin
      r_tag       <= w_tag;
      r_disp_vld  <= (r_tag == TAG_DISP);
      r_game_rvld <= (r_tag == TAG_GAME) || (r_tag == TAG_GAME_OOR);
      if (r_tag == TAG_DISP) begin
        r_disp_data <= bus.mem_rdata;
      end
      if (r_tag == TAG_GAME) begin
        r_game_rdata <= bus.mem_rdata;
      end else if (r_tag == TAG_GAME_OOR) begin
        r_game_rdata <= '0;
      end
    end
  end

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_addr_err_set) begin
      r_addr_err <= 1'b1;
    end
  end

  assign bus.disp_data  = r_disp_data;
  assign bus.disp_vld   = r_disp_vld;
  assign bus.game_gnt   = w_game_gnt;
  assign bus.game_rdata = r_game_rdata;
  assign bus.game_rvld  = r_game_rvld;
  assign bus.clear_busy = (r_state == CLEAR);
  assign bus.addr_err   = r_addr_err;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_playfield_mem_arbiter.sv
// Directed bench for playfield_mem_arbiter: a vector table for single-cycle
// behaviour plus hand-written sequences for starvation, clear, and reset abort.
module tb_playfield_mem_arbiter;

  logic pixclk = 1'b0;
  logic reset  = 1'b1;
  logic ramLoad = 1'b1;

  always #5 pixclk = ~pixclk;

  playfield_mem_arbiter_if #(.AW(8), .CW(3)) bus ();

  playfield_mem_arbiter #(.COLS(10), .ROWS(20), .CW(3), .AW(8)) dut (
    .pixclk (pixclk),
    .reset  (reset),
    .bus    (bus)
  );

  typedef struct {
    logic       dreq;
    logic [7:0] daddr;
    logic       greq;
    logic       gwe;
    logic [7:0] gaddr;
    logic [2:0] gwd;
    logic       cs;
  } stim_t;

  typedef struct {
    stim_t s;
    int gnt, en, we, addr, dvld, ddata, rvld, rdata, busy, err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // RAM model: registered read, preloaded with cell i holding i mod 8.
  logic [2:0] ram [256];
  always @(posedge pixclk) begin
    if (ramLoad) begin
      for (int i = 0; i < 256; i++) ram[i] <= 3'(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // Clear-write monitor: counts zero writes and flags any out-of-order address.
  int         clrCount = 0;
  int         clrOrderBad = 0;
  logic [7:0] clrNext = 8'd0;
  always @(posedge pixclk or posedge reset) begin
    if (reset) begin
      clrNext <= 8'd0;
    end else if (!bus.clear_busy) begin
      clrNext <= 8'd0;
    end else if (bus.mem_en && bus.mem_we) begin
      if (bus.mem_addr != clrNext || bus.mem_wdata != 3'd0) clrOrderBad <= clrOrderBad + 1;
      clrNext  <= clrNext + 8'd1;
      clrCount <= clrCount + 1;
    end
  end

  function automatic stim_t mkIn(input logic dreq, input int daddr, input logic greq,
                                 input logic gwe, input int gaddr, input int gwd, input logic cs);
    stim_t s;
    s.dreq = dreq; s.daddr = 8'(daddr); s.greq = greq; s.gwe = gwe;
    s.gaddr = 8'(gaddr); s.gwd = 3'(gwd); s.cs = cs;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input int gnt, input int en, input int we,
                                 input int addr, input int dvld, input int ddata, input int rvld,
                                 input int rdata, input int busy, input int err);
    vec_t v;
    v.s = s; v.gnt = gnt; v.en = en; v.we = we; v.addr = addr; v.dvld = dvld;
    v.ddata = ddata; v.rvld = rvld; v.rdata = rdata; v.busy = busy; v.err = err;
    return v;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(posedge pixclk);
    #1;
    bus.disp_req    = s.dreq;
    bus.disp_addr   = s.daddr;
    bus.game_req    = s.greq;
    bus.game_we     = s.gwe;
    bus.game_addr   = s.gaddr;
    bus.game_wdata  = s.gwd;
    bus.clear_start = s.cs;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    @(negedge pixclk);
    checkVal($sformatf("v%0d gnt", idx), bus.game_gnt, v.gnt);
    checkVal($sformatf("v%0d mem_en", idx), bus.mem_en, v.en);
    if (v.en != 0) begin
      checkVal($sformatf("v%0d mem_we", idx), bus.mem_we, v.we);
      checkVal($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
    end
    checkVal($sformatf("v%0d disp_vld", idx), bus.disp_vld, v.dvld);
    checkVal($sformatf("v%0d disp_data", idx), bus.disp_data, v.ddata);
    checkVal($sformatf("v%0d game_rvld", idx), bus.game_rvld, v.rvld);
    checkVal($sformatf("v%0d game_rdata", idx), bus.game_rdata, v.rdata);
    checkVal($sformatf("v%0d clear_busy", idx), bus.clear_busy, v.busy);
    checkVal($sformatf("v%0d addr_err", idx), bus.addr_err, v.err);
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, " disp_data"}, bus.disp_data, 0);
    checkVal({tag, " disp_vld"}, bus.disp_vld, 0);
    checkVal({tag, " game_rdata"}, bus.game_rdata, 0);
    checkVal({tag, " game_rvld"}, bus.game_rvld, 0);
    checkVal({tag, " clear_busy"}, bus.clear_busy, 0);
    checkVal({tag, " addr_err"}, bus.addr_err, 0);
    checkVal({tag, " mem_en"}, bus.mem_en, 0);
  endtask

  task automatic gameWrite(input int addr, input int data);
    applyStimulus(mkIn(0, 0, 1, 1, addr, data, 0));
    @(negedge pixclk);
    checkVal($sformatf("write %0d gnt", addr), bus.game_gnt, 1);
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic gameRead(input int addr, input int expData);
    applyStimulus(mkIn(0, 0, 1, 0, addr, 0, 0));
    @(negedge pixclk);
    checkVal($sformatf("read %0d gnt", addr), bus.game_gnt, 1);
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0));
    @(negedge pixclk);
    checkVal($sformatf("read %0d rvld early", addr), bus.game_rvld, 0);
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 0));
    @(negedge pixclk);
    checkVal($sformatf("read %0d rvld", addr), bus.game_rvld, 1);
    checkVal($sformatf("read %0d rdata", addr), bus.game_rdata, expData);
  endtask

  vec_t vecs[18];
  stim_t idleIn;

  initial begin
    int base, baseBad, busyLowAt, gntAt, gntBusy, iter;

    idleIn = mkIn(0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = mkVec(idleIn,                      0,0,0,0,   0,0, 0,0, 0,0);
    vecs[1]  = mkVec(mkIn(0,0,1,1,5,3,0),         1,1,1,5,   0,0, 0,0, 0,0);
    vecs[2]  = mkVec(idleIn,                      0,0,0,0,   0,0, 0,0, 0,0);
    vecs[3]  = mkVec(mkIn(0,0,1,0,5,0,0),         1,1,0,5,   0,0, 0,0, 0,0);
    vecs[4]  = mkVec(idleIn,                      0,0,0,0,   0,0, 0,0, 0,0);
    vecs[5]  = mkVec(idleIn,                      0,0,0,0,   0,0, 1,3, 0,0);
    vecs[6]  = mkVec(idleIn,                      0,0,0,0,   0,0, 0,3, 0,0);
    vecs[7]  = mkVec(mkIn(1,10,0,0,0,0,0),        0,1,0,10,  0,0, 0,3, 0,0);
    vecs[8]  = mkVec(mkIn(1,11,1,0,12,0,0),       0,1,0,11,  0,0, 0,3, 0,0);
    vecs[9]  = mkVec(mkIn(0,0,1,0,12,0,0),        1,1,0,12,  1,2, 0,3, 0,0);
    vecs[10] = mkVec(idleIn,                      0,0,0,0,   1,3, 0,3, 0,0);
    vecs[11] = mkVec(idleIn,                      0,0,0,0,   0,3, 1,4, 0,0);
    vecs[12] = mkVec(mkIn(0,0,1,1,250,5,0),       1,0,0,0,   0,3, 0,4, 0,0);
    vecs[13] = mkVec(idleIn,                      0,0,0,0,   0,3, 0,4, 0,1);
    vecs[14] = mkVec(mkIn(0,0,1,0,200,0,0),       1,0,0,0,   0,3, 0,4, 0,1);
    vecs[15] = mkVec(idleIn,                      0,0,0,0,   0,3, 0,4, 0,1);
    vecs[16] = mkVec(idleIn,                      0,0,0,0,   0,3, 1,0, 0,1);
    vecs[17] = mkVec(idleIn,                      0,0,0,0,   0,3, 0,0, 0,1);

    bus.disp_req = 0; bus.disp_addr = 0; bus.game_req = 0; bus.game_we = 0;
    bus.game_addr = 0; bus.game_wdata = 0; bus.clear_start = 0;
    repeat (3) @(posedge pixclk);
    #1;
    checkAllZero("reset");
    ramLoad = 1'b0;
    reset   = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].s);
      checkOutput(vecs[i], i);
    end

    // Scanout starves a pending game write for 8 cycles.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(mkIn(1, 16 + k, 1, 1, 7, 5, 0));
      @(negedge pixclk);
      checkVal($sformatf("starve gnt c%0d", k), bus.game_gnt, 0);
      checkVal($sformatf("starve dvld c%0d", k), bus.disp_vld, (k >= 2) ? 1 : 0);
      if (k >= 2) checkVal($sformatf("starve ddata c%0d", k), bus.disp_data, k - 2);
    end
    applyStimulus(mkIn(0, 0, 1, 1, 7, 5, 0));
    @(negedge pixclk);
    checkVal("starve gnt c8", bus.game_gnt, 1);
    checkVal("starve dvld c8", bus.disp_vld, 1);
    checkVal("starve ddata c8", bus.disp_data, 6);
    applyStimulus(idleIn);
    @(negedge pixclk);
    checkVal("starve dvld c9", bus.disp_vld, 1);
    checkVal("starve ddata c9", bus.disp_data, 7);
    applyStimulus(idleIn);
    @(negedge pixclk);
    checkVal("starve dvld c10", bus.disp_vld, 0);
    gameRead(5, 3);

    // Full clear with scanout taking every other cycle.
    base = clrCount; baseBad = clrOrderBad;
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1));
    iter = 0;
    while (iter < 1000) begin
      applyStimulus(mkIn(iter[0] == 1'b0, 0, 0, 0, 0, 0, 0));
      @(negedge pixclk);
      if (!bus.clear_busy) break;
      iter++;
    end
    checkVal("clear timeout", (iter < 1000) ? 1 : 0, 1);
    checkVal("clear write count", clrCount - base, 200);
    checkVal("clear order", clrOrderBad - baseBad, 0);
    gameRead(5, 0);

    // Reset in the middle of a clear aborts it; a new clear starts at 0.
    gameWrite(9, 6);
    gameRead(9, 6);
    gameWrite(220, 1);
    applyStimulus(mkIn(1, 9, 0, 0, 0, 0, 0));
    applyStimulus(idleIn);
    applyStimulus(idleIn);
    @(negedge pixclk);
    checkVal("pre-abort ddata", bus.disp_data, 6);
    checkVal("pre-abort err", bus.addr_err, 1);
    base = clrCount;
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1));
    iter = 0;
    while (iter < 300 && (clrCount - base) < 50) begin
      applyStimulus(idleIn);
      @(negedge pixclk);
      iter++;
    end
    checkVal("abort reached write 50", clrCount - base, 50);
    reset = 1'b1;
    #1;
    checkAllZero("abort");
    @(posedge pixclk);
    @(posedge pixclk);
    #1;
    reset = 1'b0;
    base = clrCount; baseBad = clrOrderBad;
    applyStimulus(mkIn(0, 0, 0, 0, 0, 0, 1));
    applyStimulus(idleIn);
    @(negedge pixclk);
    checkVal("restart mem_we", bus.mem_we, 1);
    checkVal("restart mem_addr", bus.mem_addr, 0);
    iter = 0;
    while (iter < 400 && bus.clear_busy) begin
      applyStimulus(idleIn);
      @(negedge pixclk);
      iter++;
    end
    checkVal("restart write count", clrCount - base, 200);
    checkVal("restart order", clrOrderBad - baseBad, 0);

    // clear_start and game_req together: clear first, game after busy falls.
    base = clrCount;
    applyStimulus(mkIn(0, 0, 1, 1, 3, 7, 1));
    @(negedge pixclk);
    checkVal("tie gnt", bus.game_gnt, 0);
    checkVal("tie mem_en", bus.mem_en, 0);
    busyLowAt = -1; gntAt = -1; gntBusy = 0;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(mkIn(0, 0, 1, 1, 3, 7, 0));
      @(negedge pixclk);
      if (c == 0) begin
        checkVal("tie first addr", bus.mem_addr, 0);
        checkVal("tie first we", bus.mem_we, 1);
      end
      if (bus.game_gnt && bus.clear_busy) gntBusy++;
      if (!bus.clear_busy && busyLowAt < 0) busyLowAt = c;
      if (bus.game_gnt) begin
        gntAt = c;
        break;
      end
    end
    checkVal("tie gnt during busy", gntBusy, 0);
    checkVal("tie gnt seen", (gntAt >= 0) ? 1 : 0, 1);
    checkVal("tie gnt at busy fall", gntAt, busyLowAt);
    checkVal("tie clear count", clrCount - base, 200);
    applyStimulus(idleIn);
    gameRead(3, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
